// File: rtl/alu_rr_arbiter.sv
// Purpose: round-robin share of one combinational ALU between two requesters.
// Latency: accept edge -> rsp_valid high after 2 edges; issue interval >= 3 cycles.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready[owner].
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]  per-requester request handshake (ready one-hot or zero)
//   req_{a,b,op,sub,cin}{0,1}  requester operands and controls
//   alu_{a,b,opcode,sub,cin}   registered drive of the shared ALU inputs
//   alu_{result,z,n,o,cout}    ALU outputs, sampled at the end of EXEC
//   rsp_valid/rsp_ready [1:0]  response handshake, bit i = owning requester
//   rsp_{result,z,n,o,cout,err} captured response (err = illegal opcode 111)
module alu_rr_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [2:0]       req_op0,
  input  logic             req_sub0,
  input  logic             req_cin0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [2:0]       req_op1,
  input  logic             req_sub1,
  input  logic             req_cin1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_opcode,
  output logic             alu_sub,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_o,
  input  logic             alu_cout,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_z,
  output logic             rsp_n,
  output logic             rsp_o,
  output logic             rsp_cout,
  output logic             rsp_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  logic [1:0] state;
  logic       owner;
  logic       last_grant;
  logic [1:0] grant;
  logic       accept;
  logic       winner;
  logic       rsp_done;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready = (state == IDLE) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign winner    = req_ready[1];
  // Only the owner's ready bit completes the response.
  assign rsp_done  = (state == RESP) && rsp_ready[owner];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= 3'b000;
      alu_sub    <= 1'b0;
      alu_cin    <= 1'b0;
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_z      <= 1'b0;
      rsp_n      <= 1'b0;
      rsp_o      <= 1'b0;
      rsp_cout   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= EXEC;
            owner      <= winner;
            last_grant <= winner;
            alu_a      <= winner ? req_a1   : req_a0;
            alu_b      <= winner ? req_b1   : req_b0;
            alu_opcode <= winner ? req_op1  : req_op0;
            alu_sub    <= winner ? req_sub1 : req_sub0;
            alu_cin    <= winner ? req_cin1 : req_cin0;
          end
        end
        EXEC: begin
          // ALU has settled on the registered operands by the end of this cycle.
          state     <= RESP;
          rsp_valid <= owner ? 2'b10 : 2'b01;
          if (alu_opcode == OP_ILLEGAL) begin
            rsp_result <= '0;
            rsp_z      <= 1'b0;
            rsp_n      <= 1'b0;
            rsp_o      <= 1'b0;
            rsp_cout   <= 1'b0;
            rsp_err    <= 1'b1;
          end else begin
            rsp_result <= alu_result;
            rsp_z      <= alu_z;
            rsp_n      <= alu_n;
            rsp_o      <= alu_o;
            rsp_cout   <= alu_cout;
            rsp_err    <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_done) begin
            state     <= IDLE;
            rsp_valid <= 2'b00;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
module tb_alu_rr_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]   req_op0, req_op1;
  logic         req_sub0, req_cin0, req_sub1, req_cin1;
  logic [W-1:0] alu_a, alu_b;
  logic [2:0]   alu_opcode;
  logic         alu_sub, alu_cin;
  logic [W-1:0] alu_result;
  logic         alu_z, alu_n, alu_o, alu_cout;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_z, rsp_n, rsp_o, rsp_cout, rsp_err;

  int nvec = 0;
  int nerr = 0;

  alu_rr_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0), .req_sub0(req_sub0), .req_cin0(req_cin0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1), .req_sub1(req_sub1), .req_cin1(req_cin1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_sub(alu_sub), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_z(alu_z), .alu_n(alu_n), .alu_o(alu_o), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_o(rsp_o), .rsp_cout(rsp_cout),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Stand-in combinational ALU; opcode 111 returns junk with all flags set.
  logic [W:0]   sum;
  logic [W-1:0] b_eff;
  always_comb begin
    b_eff    = alu_sub ? ~alu_b : alu_b;
    sum      = {1'b0, alu_a} + {1'b0, b_eff} + {{W{1'b0}}, (alu_sub | alu_cin)};
    alu_cout = 1'b0;
    alu_o    = 1'b0;
    case (alu_opcode)
      3'b000: begin
        alu_result = sum[W-1:0];
        alu_cout   = sum[W];
        alu_o      = (alu_a[W-1] == b_eff[W-1]) && (sum[W-1] != alu_a[W-1]);
      end
      3'b001:  alu_result = alu_a ^ alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = ~(alu_a | alu_b);
      3'b101:  alu_result = alu_a << alu_b[4:0];
      3'b110:  alu_result = alu_a >> alu_b[4:0];
      default: begin
        alu_result = 32'hDEAD_BEEF;
        alu_cout   = 1'b1;
        alu_o      = 1'b1;
      end
    endcase
    alu_z = (alu_result == '0) || (alu_opcode == 3'b111);
    alu_n = alu_result[W-1];
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Raise one request, wait (bounded) for its grant, pass the accept edge,
  // check nothing is valid yet, and stop one cycle later in RESP.
  task automatic issue(input int idx, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic sub, input logic cin);
    int waited;
    if (idx == 0) begin
      req_a0 = a; req_b0 = b; req_op0 = op; req_sub0 = sub; req_cin0 = cin;
      req_valid[0] = 1'b1;
    end else begin
      req_a1 = a; req_b1 = b; req_op1 = op; req_sub1 = sub; req_cin1 = cin;
      req_valid[1] = 1'b1;
    end
    #1;
    waited = 0;
    while (!req_ready[idx] && waited < 10) begin
      tick();
      waited++;
    end
    chk("grant_seen", {31'b0, req_ready[idx]}, 32'd1);
    tick();
    req_valid[idx] = 1'b0;
    chk("exec_no_rsp", {30'b0, rsp_valid}, 32'd0);
    tick();
  endtask

  task automatic complete;
    rsp_ready = 2'b11;
    tick();
    rsp_ready = 2'b00;
    chk("rsp_cleared", {30'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    req_a0 = '0; req_b0 = '0; req_op0 = '0; req_sub0 = 0; req_cin0 = 0;
    req_a1 = '0; req_b1 = '0; req_op1 = '0; req_sub1 = 0; req_cin1 = 0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    rst_n = 1'b0;
    #3;
    // Reset state
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", {29'b0, alu_opcode}, 32'd0);
    chk("rst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    do_reset();

    // Single request: ADD 5+10
    req_a0 = 5; req_b0 = 10; req_op0 = 3'b000; req_sub0 = 0; req_cin0 = 0;
    req_valid = 2'b01;
    #1;
    chk("t1_ready", {30'b0, req_ready}, 32'h1);
    tick();
    req_valid = 2'b00;
    chk("t1_exec_ready", {30'b0, req_ready}, 32'h0);
    chk("t1_alu_a", alu_a, 32'd5);
    chk("t1_alu_b", alu_b, 32'd10);
    chk("t1_exec_valid", {30'b0, rsp_valid}, 32'h0);
    tick();
    chk("t1_rsp_valid", {30'b0, rsp_valid}, 32'h1);
    chk("t1_result", rsp_result, 32'd15);
    chk("t1_zn", {30'b0, rsp_z, rsp_n}, 32'h0);
    chk("t1_err", {31'b0, rsp_err}, 32'h0);
    complete();
    chk("t1_op_held", {29'b0, alu_opcode}, 32'h0);
    chk("t1_a_held", alu_a, 32'd5);

    // Contention after reset: req0 first, then req1
    do_reset();
    req_a0 = 5; req_b0 = 9;  req_op0 = 3'b001; req_sub0 = 0; req_cin0 = 0;
    req_a1 = 6; req_b1 = 10; req_op1 = 3'b010; req_sub1 = 0; req_cin1 = 0;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    chk("t2_first_grant", {30'b0, req_ready}, 32'h1);
    tick();
    req_valid = 2'b10;
    tick();
    chk("t2_rsp0_valid", {30'b0, rsp_valid}, 32'h1);
    chk("t2_rsp0_result", rsp_result, 32'd12);
    tick();
    chk("t2_second_grant", {30'b0, req_ready}, 32'h2);
    tick();
    req_valid = 2'b00;
    tick();
    chk("t2_rsp1_valid", {30'b0, rsp_valid}, 32'h2);
    chk("t2_rsp1_result", rsp_result, 32'd2);
    tick();
    rsp_ready = 2'b00;
    req_valid = 2'b11;
    #1;
    chk("t2_rr_back_to_0", {30'b0, req_ready}, 32'h1);
    // Withdraw before the edge: nothing is accepted
    req_valid = 2'b00;
    tick();
    chk("t2_drop_ready", {30'b0, req_ready}, 32'h0);
    chk("t2_drop_op_held", {29'b0, alu_opcode}, 32'h2);

    // Backpressure on requester 1 while requester 0 waits
    rsp_ready = 2'b01;  // non-owner bit must be ignored
    req_a1 = 7; req_b1 = 11; req_op1 = 3'b011;
    req_valid = 2'b10;
    #1;
    chk("t3_grant1", {30'b0, req_ready}, 32'h2);
    tick();
    req_a0 = 1; req_b0 = 2; req_op0 = 3'b000; req_sub0 = 0; req_cin0 = 0;
    req_valid = 2'b01;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", {30'b0, rsp_valid}, 32'h2);
      chk("t3_hold_result", rsp_result, 32'd15);
      chk("t3_hold_ready", {30'b0, req_ready}, 32'h0);
      tick();
    end
    rsp_ready = 2'b10;
    tick();
    chk("t3_idle_grant0", {30'b0, req_ready}, 32'h1);
    tick();
    req_valid = 2'b00;
    chk("t3_alu_a", alu_a, 32'd1);
    tick();
    chk("t3_rsp0_result", rsp_result, 32'd3);
    tick();  // rsp_ready=10 does not complete owner 0
    chk("t3_nonowner_ignored", {30'b0, rsp_valid}, 32'h1);
    complete();

    // Subtract to zero, then carry-in
    issue(0, 3'b000, 32'd6, 32'd6, 1'b1, 1'b0);
    chk("t4_sub_result", rsp_result, 32'd0);
    chk("t4_sub_z", {31'b0, rsp_z}, 32'h1);
    complete();
    issue(0, 3'b000, 32'd6, 32'd5, 1'b0, 1'b1);
    chk("t4_cin_result", rsp_result, 32'd12);
    chk("t4_cin_z", {31'b0, rsp_z}, 32'h0);
    complete();
    issue(1, 3'b101, 32'd3, 32'd4, 1'b0, 1'b0);
    chk("t4_sl_result", rsp_result, 32'd48);
    complete();

    // Illegal opcode
    issue(1, 3'b111, 32'd7, 32'd3, 1'b0, 1'b0);
    chk("t5_valid", {30'b0, rsp_valid}, 32'h2);
    chk("t5_err", {31'b0, rsp_err}, 32'h1);
    chk("t5_result", rsp_result, 32'd0);
    chk("t5_flags", {28'b0, rsp_z, rsp_n, rsp_o, rsp_cout}, 32'h0);
    complete();

    // Reset during EXEC
    req_a0 = 5; req_b0 = 9; req_op0 = 3'b100; req_sub0 = 0; req_cin0 = 0;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    chk("t6_in_exec_op", {29'b0, alu_opcode}, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_op", {29'b0, alu_opcode}, 32'h0);
    chk("t6_async_a", alu_a, 32'd0);
    chk("t6_async_err", {31'b0, rsp_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_rsp", {30'b0, rsp_valid}, 32'h0);
    end
    req_valid = 2'b11;
    #1;
    chk("t6_grant0_first", {30'b0, req_ready}, 32'h1);
    req_valid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed no finish, expected finish before 50000");
    $fatal(1, "watchdog");
  end

endmodule
